// File: rtl/xnor_mux_arbiter.sv
// xnor_mux_arbiter: round-robin two-requester burst arbiter driving a shared 1-bit mux lane
module xnor_mux_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic d0,
  input  logic d1,
  input  logic last0,
  input  logic last1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic out_valid,
  output logic out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             out_q, out_d, out_valid_q, out_valid_d;
  logic             busy, cur, req_x, req_y, last_x, d_x, beat, burst_end;
  // next-state, beat and burst-end decode from the current owner's view
  always_comb begin
    busy        = (state_q == G0) || (state_q == G1);
    cur         = state_q == G1;
    req_x       = cur ? req1 : req0;
    req_y       = cur ? req0 : req1;
    last_x      = cur ? last1 : last0;
    d_x         = cur ? d1 : d0;
    beat        = busy && req_x;
    cnt_inc     = cnt_q + 1'b1;
    burst_end   = busy && (!req_x || last_x || cnt_inc == MAX_C);
    state_d     = busy ? (burst_end ? (req_y ? (cur ? G0 : G1) : (req_x ? state_q : IDLE)) : state_q)
                       : (req0 && req1 ? (prio_q ? G1 : G0) : req0 ? G0 : req1 ? G1 : IDLE);
    prio_d      = burst_end ? ~cur : prio_q;
    cnt_d       = burst_end ? '0 : beat ? cnt_inc : cnt_q;
    out_valid_d = beat;
    out_d       = beat && d_x;
  end
  // state, priority, beat count and registered lane output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign gnt0      = state_q == G0;
  assign gnt1      = state_q == G1;
  assign sel       = state_q == G1;
  assign out_valid = out_valid_q;
  assign out       = out_q;
endmodule

// File: tb/tb_xnor_mux_arbiter.sv
// tb_xnor_mux_arbiter: scoreboard bench comparing the arbiter against a cycle model
module tb_xnor_mux_arbiter;
  logic clk = 1'b0;
  logic rst, req0, req1, d0, d1, last0, last1;
  logic gnt0, gnt1, sel, out_valid, out_w;
  int errors = 0;
  int checks = 0;
  int m_state = 0;
  int m_cnt = 0;
  logic m_prio = 1'b0;
  logic m_ov = 1'b0;
  logic m_out = 1'b0;
  logic [4:0] exp_q[$];
  xnor_mux_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .last0(last0), .last1(last1), .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_valid(out_valid), .out(out_w)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {gnt0,gnt1,sel,ov,out}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic q0, input logic q1,
                      input logic x0, input logic x1, input logic l0, input logic l1);
    logic rx, ry, lx, dx, fin;
    logic [4:0] got;
    @(negedge clk);
    rst = r; req0 = q0; req1 = q1; d0 = x0; d1 = x1; last0 = l0; last1 = l1;
    if (r) begin
      m_state = 0; m_prio = 1'b0; m_cnt = 0; m_ov = 1'b0; m_out = 1'b0;
    end else if (m_state == 0) begin
      m_ov = 1'b0; m_out = 1'b0;
      if (q0 && q1) m_state = m_prio ? 2 : 1;
      else if (q0) m_state = 1;
      else if (q1) m_state = 2;
    end else begin
      rx = (m_state == 1) ? q0 : q1;
      ry = (m_state == 1) ? q1 : q0;
      lx = (m_state == 1) ? l0 : l1;
      dx = (m_state == 1) ? x0 : x1;
      m_ov = rx;
      m_out = rx & dx;
      fin = 1'b0;
      if (!rx) fin = 1'b1;
      else begin
        m_cnt++;
        if (lx || m_cnt == 4) fin = 1'b1;
      end
      if (fin) begin
        m_prio = (m_state == 1);
        m_cnt = 0;
        if (ry) m_state = 3 - m_state;
        else if (!rx) m_state = 0;
      end
    end
    exp_q.push_back({m_state == 1, m_state == 2, m_state == 2, m_ov, m_out});
    @(posedge clk);
    #1;
    got = {gnt0, gnt1, sel, out_valid, out_w};
    check(tag, got, exp_q.pop_front());
  endtask
  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 1'b0; d1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    repeat (2) step("reset_all_ones", 1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 14; i++) step("rr_both", 0, 1, 1, 1'($urandom), 1'($urandom), 0, 0);
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("single_grant", 0, 1, 0, 0, 0, 0, 0);
    step("single_b1", 0, 1, 0, 1, 0, 0, 0);
    step("single_b2", 0, 1, 0, 0, 0, 0, 0);
    step("single_b3", 0, 1, 0, 1, 0, 1, 0);
    repeat (3) step("single_idle", 0, 0, 0, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("last0_grant", 0, 1, 1, 1, 0, 0, 0);
    step("last0_first", 0, 1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) step("last0_after", 0, 1, 1, 1'($urandom), 1'($urandom), 0, 0);
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("g1_grant", 0, 0, 1, 0, 1, 0, 0);
    step("g1_b1", 0, 0, 1, 0, 1, 0, 0);
    step("g1_b2", 0, 0, 1, 0, 0, 0, 0);
    step("g1_drop", 0, 0, 0, 0, 0, 0, 0);
    step("g1_idle", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step("g1_regrant", 0, 0, 1, 0, 1, 0, 0);
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    step("rst_mid_grant", 0, 0, 1, 0, 1, 0, 0);
    step("rst_mid_b1", 0, 0, 1, 0, 1, 0, 0);
    step("rst_mid_b2", 1, 1, 1, 1, 1, 0, 0);
    repeat (3) step("rst_mid_after", 0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xnor_mux_arbiter.md
# xnor_mux_arbiter

Round-robin arbiter and sequencer for the shared 2:1 XNOR-style mux path. Two requesters compete for one single-bit output lane. The block grants one requester at a time for a bounded burst and drives the mux select. It registers the selected data bit and a valid strobe toward the downstream consumer.

## Interface
- MAX_BURST, 4, maximum beats per grant; legal range 1..15
- CNT_W, 4, width of the beat counter; must hold MAX_BURST
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 wants the lane / has a beat available
- req1  input  1  requester 1 wants the lane / has a beat available
- d0  input  1  requester 0 data bit
- d1  input  1  requester 1 data bit
- last0  input  1  requester 0: current beat is final of its burst
- last1  input  1  requester 1: current beat is final of its burst
- gnt0  output  1  requester 0 owns the lane (decoded from state)
- gnt1  output  1  requester 1 owns the lane (decoded from state)
- sel  output  1  mux select: 1 when requester 1 granted, else 0
- out_valid  output  1  out carries a transferred beat
- out  output  1  registered data bit of accepted beat; 0 when out_valid=0

## Operation
- FSM states: IDLE, G0, G1. gnt0=(state==G0), gnt1=(state==G1), sel=(state==G1). No glitch paths from inputs to gnt/sel.
- prio register: 0 = requester 0 wins a tie, 1 = requester 1 wins.
- IDLE: req0&req1 -> G(prio). Only reqX -> GX. Neither -> IDLE.
- Beat: a rising edge with state==GX and reqX=1. On a beat: out<=dX, out_valid<=1, cnt<=cnt+1. Otherwise out_valid<=0, out<=0.
- Burst ends on the edge where any of these holds:
  - a beat with lastX=1;
  - a beat that makes cnt reach MAX_BURST;
  - reqX=0 in GX. This edge is not a beat.
- On burst end:
  - prio <= other requester; cnt <= 0.
  - Next state: the other requester's reqY=1 -> GY. Else reqX=1 and the end was not a deassertion -> GX (re-grant, fresh count). Else IDLE.
- The switch G0<->G1 takes no idle bubble.
- No burst end: stay GX.
- cnt width CNT_W; never exceeds MAX_BURST; never wraps.
- MAX_BURST=1: every beat ends its burst. With both requesting, grants alternate every cycle.

## Timing
- Reset (rst=1 at an edge): state=IDLE, prio=0, cnt=0, gnt0=gnt1=0, sel=0, out_valid=0, out=0. These values are visible in the cycle after that edge.
- Reset mid-burst abandons the burst. No beat is produced on the reset edge. Arbitration restarts from IDLE with prio=0.
- Request to grant: req first sampled at edge n in IDLE -> gnt/sel high after edge n. The first beat is taken at edge n+1 if req still high.
- Beat to output: beat at edge k -> out_valid=1 and out=dX during cycle k..k+1. Latency 1 cycle.
- Sustained throughput: 1 beat/cycle within a burst and across G0<->G1 handoffs. A single requester loses 1 cycle per IDLE visit only.
- Simultaneous req0/req1 rise in IDLE: prio decides; the loser waits for the winner's burst end.
- lastX together with the MAX_BURST count on the same beat: a single burst end, prio flips once.

## Test plan
- Hold rst=1 for 2 cycles with all inputs at 1 -> gnt0=gnt1=sel=out_valid=out=0. After release with req0=req1=1, gnt0 rises first (prio=0).
- req0 only, d0=1,0,1, last0 on the 3rd beat, req0 then low -> gnt0 high 3 cycles, out_valid high 3 cycles with out=1,0,1 one cycle delayed, then IDLE with gnt0=0.
- MAX_BURST=4, req0=req1=1 continuously, no last -> gnt0 for 4 cycles, gnt1 for 4, gnt0 for 4, and so on. sel tracks gnt1. out_valid is continuously 1 after the first beat.
- req0=req1=1, last0=1 on requester 0's first beat -> gnt1/sel=1 on the next cycle. Requester 1 gets a full 4-beat burst, then back to G0.
- In G1 after 2 beats, req1 drops and req0=0 -> state IDLE next cycle, out_valid=0, prio=0. A later req1 alone is granted.
- rst asserted during the 2nd beat of a G1 burst -> next cycle gnt1=sel=out_valid=0. With both requesting after release, gnt0 wins.
